// File: rtl/cic_host_mem.sv
// rtl/cic_host_mem.sv - host-side image/layer memory responder for the CIC convolution core
module cic_host_mem #(
   parameter int DW   = 20,
   parameter int AW   = 12,
   parameter int L0_D = 4096,
   parameter int L1_D = 1024,
   parameter int L2_D = 2048
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_start,
   input  logic          load_valid,
   input  logic [DW-1:0] load_data,
   output logic          load_ready,
   input  logic          start,
   output logic          ready,
   input  logic          busy,
   input  logic [AW-1:0] iaddr,
   output logic [DW-1:0] idata,
   input  logic          crd,
   input  logic [AW-1:0] caddr_rd,
   output logic [DW-1:0] cdata_rd,
   input  logic          cwr,
   input  logic [AW-1:0] caddr_wr,
   input  logic [DW-1:0] cdata_wr,
   input  logic [2:0]    csel,
   output logic          done,
   input  logic [2:0]    dump_sel,
   input  logic [AW-1:0] dump_addr,
   output logic [DW-1:0] dump_data,
   output logic [1:0]    err
);

   localparam int L0_AW = $clog2(L0_D);
   localparam int L1_AW = $clog2(L1_D);
   localparam int L2_AW = $clog2(L2_D);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      LOADED = 3'd2,
      ARM    = 3'd3,
      RUN    = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t        state;
   logic [AW-1:0] load_addr;

   // Storage is never reset: the image survives a reset and must be reloaded to be trusted.
   logic [DW-1:0] img   [2**AW];
   logic [DW-1:0] l0_k0 [L0_D];
   logic [DW-1:0] l0_k1 [L0_D];
   logic [DW-1:0] l1_k0 [L1_D];
   logic [DW-1:0] l1_k1 [L1_D];
   logic [DW-1:0] l2_fl [L2_D];

   // A load_start outside RUN restarts preload; inside RUN the core owns the image.
   logic load_restart;
   assign load_restart = load_start && (state != RUN);

   function automatic logic sel_ok(input logic [2:0] s);
      sel_ok = (s >= 3'd1) && (s <= 3'd5);
   endfunction

   // True only for a valid bank with the address inside its depth.
   function automatic logic addr_ok(input logic [2:0] s, input logic [AW-1:0] a);
      logic [31:0] aw;
      aw = 32'(a);
      case (s)
         3'd1, 3'd2: addr_ok = aw < L0_D;
         3'd3, 3'd4: addr_ok = aw < L1_D;
         3'd5:       addr_ok = aw < L2_D;
         default:    addr_ok = 1'b0;
      endcase
   endfunction

   // Raw bank read; callers gate the result with addr_ok so aliased indices never leak out.
   function automatic logic [DW-1:0] bank_word(input logic [2:0] s, input logic [AW-1:0] a);
      case (s)
         3'd1:    bank_word = l0_k0[a[L0_AW-1:0]];
         3'd2:    bank_word = l0_k1[a[L0_AW-1:0]];
         3'd3:    bank_word = l1_k0[a[L1_AW-1:0]];
         3'd4:    bank_word = l1_k1[a[L1_AW-1:0]];
         3'd5:    bank_word = l2_fl[a[L2_AW-1:0]];
         default: bank_word = '0;
      endcase
   endfunction

   // Control FSM: preload, arm handshake with the core, run tracking and completion flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         load_addr  <= '0;
         load_ready <= 1'b0;
         ready      <= 1'b0;
         done       <= 1'b0;
      end else if (load_restart) begin
         state      <= LOAD;
         load_addr  <= '0;
         load_ready <= 1'b1;
         ready      <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (load_valid) begin
                  load_addr <= load_addr + 1'b1;
                  if (load_addr == {AW{1'b1}}) begin
                     state      <= LOADED;
                     load_ready <= 1'b0;
                  end
               end
            end
            LOADED: begin
               if (start) begin
                  state <= ARM;
                  ready <= 1'b1;
               end
            end
            ARM: begin
               if (busy) begin
                  state <= RUN;
                  ready <= 1'b0;
               end
            end
            RUN: begin
               if (!busy) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               if (start) begin
                  state <= ARM;
                  ready <= 1'b1;
                  done  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Image preload write; a restart in the same cycle wins over the data word.
   always_ff @(posedge clk) begin
      if ((state == LOAD) && load_valid && !load_start)
         img[load_addr] <= load_data;
   end

   // Layer bank writes; invalid selects and out-of-range addresses are dropped.
   always_ff @(posedge clk) begin
      if (cwr && addr_ok(csel, caddr_wr)) begin
         case (csel)
            3'd1:    l0_k0[caddr_wr[L0_AW-1:0]] <= cdata_wr;
            3'd2:    l0_k1[caddr_wr[L0_AW-1:0]] <= cdata_wr;
            3'd3:    l1_k0[caddr_wr[L1_AW-1:0]] <= cdata_wr;
            3'd4:    l1_k1[caddr_wr[L1_AW-1:0]] <= cdata_wr;
            3'd5:    l2_fl[caddr_wr[L2_AW-1:0]] <= cdata_wr;
            default: ;
         endcase
      end
   end

   // Registered read ports: image, layer and dump; reads see pre-write contents.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idata     <= '0;
         cdata_rd  <= '0;
         dump_data <= '0;
      end else begin
         if (busy)
            idata <= img[iaddr];
         if (crd)
            cdata_rd <= addr_ok(csel, caddr_rd) ? bank_word(csel, caddr_rd) : '0;
         if (dump_sel == 3'd0)
            dump_data <= img[dump_addr];
         else
            dump_data <= addr_ok(dump_sel, dump_addr) ? bank_word(dump_sel, dump_addr) : '0;
      end
   end

   // Sticky access errors, cleared only by reset or an honoured load_start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err <= 2'b00;
      end else if (load_restart) begin
         err <= 2'b00;
      end else begin
         if ((crd || cwr) && !sel_ok(csel))
            err[0] <= 1'b1;
         if ((crd && sel_ok(csel) && !addr_ok(csel, caddr_rd)) ||
             (cwr && sel_ok(csel) && !addr_ok(csel, caddr_wr)))
            err[1] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cic_host_mem.sv
// tb/tb_cic_host_mem.sv - directed table-driven bench for cic_host_mem
module tb_cic_host_mem;
   localparam int DW = 20;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          reset;
   logic          load_start, load_valid, start, busy, crd, cwr;
   logic [DW-1:0] load_data, cdata_wr;
   logic [AW-1:0] iaddr, caddr_rd, caddr_wr, dump_addr;
   logic [2:0]    csel, dump_sel;
   logic          load_ready, ready, done;
   logic [DW-1:0] idata, cdata_rd, dump_data;
   logic [1:0]    err;

   int tests = 0;
   int fails = 0;

   cic_host_mem #(.DW(DW), .AW(AW), .L0_D(4096), .L1_D(1024), .L2_D(2048)) dut (
      .clk(clk), .reset(reset),
      .load_start(load_start), .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .start(start), .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
      .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
      .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel),
      .done(done), .dump_sel(dump_sel), .dump_addr(dump_addr), .dump_data(dump_data), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          cwr;
      logic          crd;
      logic [2:0]    csel;
      logic [AW-1:0] waddr;
      logic [DW-1:0] wdata;
      logic [AW-1:0] raddr;
      logic [DW-1:0] exp_rd;
      logic [1:0]    exp_err;
   } vec_t;

   vec_t vt [20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //         cwr   crd   csel  waddr     wdata       raddr     exp_rd      exp_err
      vt[0]  = '{1'b1, 1'b0, 3'd1, 12'h005, 20'hABCDE, 12'h000, 20'h00000, 2'b00};
      vt[1]  = '{1'b1, 1'b0, 3'd3, 12'h000, 20'h0AAAA, 12'h000, 20'h00000, 2'b00};
      vt[2]  = '{1'b0, 1'b1, 3'd1, 12'h000, 20'h00000, 12'h005, 20'hABCDE, 2'b00};
      vt[3]  = '{1'b1, 1'b0, 3'd1, 12'h006, 20'h00011, 12'h000, 20'hABCDE, 2'b00};
      vt[4]  = '{1'b1, 1'b1, 3'd1, 12'h006, 20'h00022, 12'h006, 20'h00011, 2'b00};
      vt[5]  = '{1'b0, 1'b1, 3'd1, 12'h000, 20'h00000, 12'h006, 20'h00022, 2'b00};
      vt[6]  = '{1'b1, 1'b0, 3'd2, 12'hFFF, 20'h12345, 12'h000, 20'h00022, 2'b00};
      vt[7]  = '{1'b0, 1'b1, 3'd2, 12'h000, 20'h00000, 12'hFFF, 20'h12345, 2'b00};
      vt[8]  = '{1'b0, 1'b1, 3'd1, 12'h000, 20'h00000, 12'h005, 20'hABCDE, 2'b00};
      vt[9]  = '{1'b1, 1'b0, 3'd4, 12'h3FF, 20'h54321, 12'h000, 20'hABCDE, 2'b00};
      vt[10] = '{1'b0, 1'b1, 3'd4, 12'h000, 20'h00000, 12'h3FF, 20'h54321, 2'b00};
      vt[11] = '{1'b1, 1'b0, 3'd5, 12'h7FF, 20'h0F0F0, 12'h000, 20'h54321, 2'b00};
      vt[12] = '{1'b0, 1'b1, 3'd5, 12'h000, 20'h00000, 12'h7FF, 20'h0F0F0, 2'b00};
      vt[13] = '{1'b1, 1'b0, 3'd6, 12'h007, 20'hFFFFF, 12'h000, 20'h0F0F0, 2'b01};
      vt[14] = '{1'b0, 1'b1, 3'd6, 12'h000, 20'h00000, 12'h007, 20'h00000, 2'b01};
      vt[15] = '{1'b1, 1'b0, 3'd3, 12'h400, 20'h77777, 12'h000, 20'h00000, 2'b11};
      vt[16] = '{1'b0, 1'b1, 3'd3, 12'h000, 20'h00000, 12'h000, 20'h0AAAA, 2'b11};
      vt[17] = '{1'b0, 1'b1, 3'd3, 12'h000, 20'h00000, 12'h400, 20'h00000, 2'b11};
      vt[18] = '{1'b0, 1'b1, 3'd1, 12'h000, 20'h00000, 12'h005, 20'hABCDE, 2'b11};
      vt[19] = '{1'b0, 1'b1, 3'd5, 12'h000, 20'h00000, 12'h800, 20'h00000, 2'b11};

      reset = 1'b0;
      load_start = 1'b0; load_valid = 1'b0; load_data = '0; start = 1'b0; busy = 1'b0;
      iaddr = '0; crd = 1'b0; caddr_rd = '0; cwr = 1'b0; caddr_wr = '0; cdata_wr = '0;
      csel = 3'd0; dump_sel = 3'd1; dump_addr = '0;
      tick(); tick();
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_load_ready", 32'(load_ready), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_idata", 32'(idata), 32'd0);
      chk("rst_cdata_rd", 32'(cdata_rd), 32'd0);
      reset = 1'b1;
      tick();

      // preload img[i] = i with a stall cycle and an ignored start in the middle
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      chk("load_ready_rise", 32'(load_ready), 32'd1);
      for (int i = 0; i < 4096; i++) begin
         if (i == 2000) begin
            load_valid = 1'b0;
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("start_in_load_ignored", 32'(ready), 32'd0);
         end
         if (i == 4095)
            chk("load_ready_before_last", 32'(load_ready), 32'd1);
         load_valid = 1'b1;
         load_data = DW'(i);
         tick();
      end
      load_valid = 1'b0;
      chk("load_ready_fall", 32'(load_ready), 32'd0);
      chk("loaded_ready_low", 32'(ready), 32'd0);

      // arm handshake and image reads
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("arm_ready", 32'(ready), 32'd1);
      tick();
      chk("arm_ready_held", 32'(ready), 32'd1);
      busy = 1'b1;
      iaddr = 12'h07F;
      tick();
      chk("run_ready_low", 32'(ready), 32'd0);
      chk("idata_07f", 32'(idata), 32'h0007F);
      iaddr = 12'hFFF;
      tick();
      chk("idata_fff", 32'(idata), 32'h00FFF);

      // layer access vectors
      for (int v = 0; v < 20; v++) begin
         cwr = vt[v].cwr; crd = vt[v].crd; csel = vt[v].csel;
         caddr_wr = vt[v].waddr; cdata_wr = vt[v].wdata; caddr_rd = vt[v].raddr;
         tick();
         chk($sformatf("vec%0d_rd", v), 32'(cdata_rd), 32'(vt[v].exp_rd));
         chk($sformatf("vec%0d_err", v), 32'(err), 32'(vt[v].exp_err));
      end
      cwr = 1'b0; crd = 1'b0; csel = 3'd0;

      // core finishes; idata holds while busy is low
      busy = 1'b0;
      iaddr = 12'h005;
      tick();
      chk("done_set", 32'(done), 32'd1);
      chk("idata_hold", 32'(idata), 32'h00FFF);

      dump_sel = 3'd1; dump_addr = 12'h005;
      tick();
      chk("dump_l0k0_5", 32'(dump_data), 32'hABCDE);
      dump_sel = 3'd0; dump_addr = 12'h123;
      tick();
      chk("dump_img_123", 32'(dump_data), 32'h00123);
      dump_sel = 3'd3; dump_addr = 12'h400;
      tick();
      chk("dump_oob", 32'(dump_data), 32'h00000);
      chk("done_sticky", 32'(done), 32'd1);

      // rerun from DONE
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("rerun_done_clr", 32'(done), 32'd0);
      chk("rerun_ready", 32'(ready), 32'd1);
      busy = 1'b1;
      tick();
      chk("rerun_ready_low", 32'(ready), 32'd0);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      chk("load_start_in_run_ignored", 32'(load_ready), 32'd0);
      chk("err_kept_in_run", 32'(err), 32'd3);

      // asynchronous reset during RUN
      #2;
      reset = 1'b0;
      #2;
      chk("midrun_rst_ready", 32'(ready), 32'd0);
      chk("midrun_rst_done", 32'(done), 32'd0);
      chk("midrun_rst_err", 32'(err), 32'd0);
      chk("midrun_rst_cdata", 32'(cdata_rd), 32'd0);
      busy = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("start_after_rst_ignored", 32'(ready), 32'd0);
      dump_sel = 3'd0; dump_addr = 12'h07F;
      tick();
      chk("img_retained", 32'(dump_data), 32'h0007F);

      // err cleared by load_start; a partial reload does not reach LOADED
      csel = 3'd7; crd = 1'b1;
      tick();
      crd = 1'b0; csel = 3'd0;
      chk("err_csel7", 32'(err), 32'd1);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      chk("err_cleared_by_load", 32'(err), 32'd0);
      for (int i = 0; i < 16; i++) begin
         load_valid = 1'b1;
         load_data = DW'(i);
         tick();
      end
      load_valid = 1'b0;
      chk("partial_load_ready", 32'(load_ready), 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("partial_start_ignored", 32'(ready), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, tests=%0d", tests);
      $fatal(1);
   end
endmodule
